// File: rtl/decode_if.sv
// Upstream/downstream handshake bundle for decode_stage.
// The slave modport is the stage's view. The master modport is the driver/consumer view.
interface decode_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [ILEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [3:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage with a main output register and one skid register.
// Fields are decoded combinationally at the input and registered on acceptance.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  decode_if.slave  bus
);
  localparam logic [3:0] OPC_UNKNOWN = 4'd0;
  localparam logic [3:0] OPC_LUI     = 4'd1;
  localparam logic [3:0] OPC_AUIPC   = 4'd2;
  localparam logic [3:0] OPC_JAL     = 4'd3;
  localparam logic [3:0] OPC_JALR    = 4'd4;
  localparam logic [3:0] OPC_BRANCH  = 4'd5;
  localparam logic [3:0] OPC_LOAD    = 4'd6;
  localparam logic [3:0] OPC_STORE   = 4'd7;
  localparam logic [3:0] OPC_OP_IMM  = 4'd8;
  localparam logic [3:0] OPC_OP      = 4'd9;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } dec_t;

  logic [31:0]     instr;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  dec_t            dec;

  assign instr = bus.in_instr[31:0];

  // All immediates sign-extend from instr[31], including U on wide datapaths.
  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

  always_comb begin
    dec         = '0;
    dec.pc      = bus.in_pc;
    dec.rd      = instr[11:7];
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.funct3  = instr[14:12];
    dec.funct7  = instr[31:25];
    dec.opcode  = OPC_UNKNOWN;
    dec.illegal = 1'b1;
    if (instr[1:0] == 2'b11) begin
      dec.illegal = 1'b0;
      case (instr[6:2])
        5'b01101: begin dec.opcode = OPC_LUI;    dec.imm = imm_u; end
        5'b00101: begin dec.opcode = OPC_AUIPC;  dec.imm = imm_u; end
        5'b11011: begin dec.opcode = OPC_JAL;    dec.imm = imm_j; end
        5'b11001: begin
          dec.opcode  = OPC_JALR;
          dec.imm     = imm_i;
          dec.illegal = (instr[14:12] != 3'd0);
        end
        5'b11000: begin dec.opcode = OPC_BRANCH; dec.imm = imm_b; end
        5'b00000: begin dec.opcode = OPC_LOAD;   dec.imm = imm_i; end
        5'b01000: begin dec.opcode = OPC_STORE;  dec.imm = imm_s; end
        5'b00100: begin dec.opcode = OPC_OP_IMM; dec.imm = imm_i; end
        5'b01100: begin
          dec.opcode = OPC_OP;
          // Only the SUB/SRA encodings are allowed to use funct7=0x20.
          if (instr[31:25] == 7'h20)
            dec.illegal = (instr[14:12] != 3'd0) && (instr[14:12] != 3'd5);
          else
            dec.illegal = (instr[31:25] != 7'h00);
        end
        default: begin dec.opcode = OPC_UNKNOWN; dec.illegal = 1'b1; end
      endcase
    end
  end

  dec_t main_q, main_d, skid_q, skid_d;
  logic main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic in_ready_q;
  logic accept, drain;

  assign accept = bus.in_valid && in_ready_q;
  assign drain  = main_valid_q && bus.out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end
    end else if (drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d = dec;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = main_valid_q;
  assign bus.out_pc      = main_q.pc;
  assign bus.out_opcode  = main_q.opcode;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_rs1     = main_q.rs1;
  assign bus.out_rs2     = main_q.rs2;
  assign bus.out_funct3  = main_q.funct3;
  assign bus.out_funct7  = main_q.funct7;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_illegal = main_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: stimulus pushes expected records, a negedge
// monitor pops and compares every output transfer.
module tb_decode_stage;
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  decode_if #(.XLEN(32), .ILEN(32)) bus ();
  decode_if #(.XLEN(64), .ILEN(32)) bus64 ();

  decode_stage #(.XLEN(32), .ILEN(32)) dut (
    .clk(clk), .reset(rst), .flush(flush), .bus(bus.slave)
  );

  decode_stage #(.XLEN(64), .ILEN(32)) dut64 (
    .clk(clk), .reset(rst), .flush(flush), .bus(bus64.slave)
  );

  function automatic exp_t mk(input logic [31:0] pc, input logic [3:0] op,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic ill);
    exp_t e;
    e = '{pc, op, rd, rs1, rs2, f3, f7, imm, ill};
    return e;
  endfunction

  // Monitor: every transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t act, want;
    if (!rst && bus.out_valid && bus.out_ready) begin
      act = '{bus.out_pc, bus.out_opcode, bus.out_rd, bus.out_rs1, bus.out_rs2,
              bus.out_funct3, bus.out_funct7, bus.out_imm, bus.out_illegal};
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_xfer: got pc=%h op=%0d, required no output", act.pc, act.opcode);
      end else begin
        want = exp_q.pop_front();
        if (act !== want) begin
          mismatched++;
          $display("FAIL xfer pc=%h: got op=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h imm=%h ill=%b, required pc=%h op=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h imm=%h ill=%b",
                   want.pc, act.opcode, act.rd, act.rs1, act.rs2, act.funct3, act.funct7, act.imm, act.illegal,
                   want.pc, want.opcode, want.rd, want.rs1, want.rs2, want.funct3, want.funct7, want.imm, want.illegal);
        end else begin
          $display("xfer pc=%h op=%0d imm=%h ill=%b ok", act.pc, act.opcode, act.imm, act.illegal);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end else begin
      $display("check %s = %h ok", name, got);
    end
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    compared++;
    if (acc) begin
      exp_q.push_back(e);
      $display("send pc=%h instr=%h accepted", pc, instr);
    end else begin
      mismatched++;
      $display("FAIL accept_timeout pc=%h: got in_ready=0 for 50 cycles, required acceptance", pc);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.in_pc = '0; bus64.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_illegal", 64'(bus.out_illegal), 64'd0);
    check("reset_out_pc", 64'(bus.out_pc), 64'd0);

    // Basic decode, back-to-back with downstream always ready.
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(32'hFFF00093, 32'h100, mk(32'h100, 4'd8, 5'd1, 5'd0, 5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 1'b0));
    @(negedge clk);
    check("latency1_out_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk); #1;
    send(32'h00112623, 32'h104, mk(32'h104, 4'd7, 5'd12, 5'd2, 5'd1, 3'd2, 7'h00, 32'h0000000C, 1'b0));
    send(32'hFFDFF06F, 32'h108, mk(32'h108, 4'd3, 5'd0, 5'd31, 5'd29, 3'd7, 7'h7F, 32'hFFFFFFFC, 1'b0));
    send(32'h0000007F, 32'h10C, mk(32'h10C, 4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 1'b1));
    send(32'h002081B3, 32'h110, mk(32'h110, 4'd9, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0, 1'b0));
    send(32'h40209133, 32'h114, mk(32'h114, 4'd9, 5'd2, 5'd1, 5'd2, 3'd1, 7'h20, 32'h0, 1'b1));
    send(32'h00109067, 32'h118, mk(32'h118, 4'd4, 5'd0, 5'd1, 5'd1, 3'd1, 7'h00, 32'h1, 1'b1));
    send(32'h800000B7, 32'h11C, mk(32'h11C, 4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h40, 32'h80000000, 1'b0));
    send(32'hFE208CE3, 32'h120, mk(32'h120, 4'd5, 5'd25, 5'd1, 5'd2, 3'd0, 7'h7F, 32'hFFFFFFF8, 1'b0));
    send(32'h00000010, 32'h124, mk(32'h124, 4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 1'b1));
    wait_drain("drain_basic");

    // 64-bit datapath: U immediate sign-extends above bit 31.
    bus64.in_valid = 1'b1; bus64.in_instr = 32'h800000B7; bus64.in_pc = 64'h40;
    @(posedge clk); #1;
    bus64.in_valid = 1'b0;
    @(negedge clk);
    check("x64_out_valid", 64'(bus64.out_valid), 64'd1);
    check("x64_lui_imm", bus64.out_imm, 64'hFFFFFFFF80000000);

    // Backpressure: A and B fill main+skid, C must wait until release.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(32'h00000013, 32'h200, mk(32'h200, 4'd8, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 1'b0));
    send(32'h00100093, 32'h204, mk(32'h204, 4'd8, 5'd1, 5'd0, 5'd1, 3'd0, 7'h00, 32'h1, 1'b0));
    @(negedge clk);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("hold_out_pc", 64'(bus.out_pc), 64'h200);
    @(posedge clk); #1;
    @(negedge clk);
    check("hold_out_pc_2", 64'(bus.out_pc), 64'h200);
    @(posedge clk); #1;
    fork
      send(32'h00200113, 32'h208, mk(32'h208, 4'd8, 5'd2, 5'd0, 5'd2, 3'd0, 7'h00, 32'h2, 1'b0));
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    wait_drain("drain_backpressure");

    // Flush with main+skid full and a live input: nothing of it may surface.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(32'h00000013, 32'h300, mk(32'h300, 4'd8, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 1'b0));
    send(32'h00000013, 32'h304, mk(32'h304, 4'd8, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 1'b0));
    bus.in_valid = 1'b1; bus.in_instr = 32'h00000013; bus.in_pc = 32'h308;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(32'h00300193, 32'h30C, mk(32'h30C, 4'd8, 5'd3, 5'd0, 5'd3, 3'd0, 7'h00, 32'h3, 1'b0));
    wait_drain("drain_after_flush");

    // Reset while holding an illegal instruction.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(32'h0000007F, 32'h400, mk(32'h400, 4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 1'b1));
    @(negedge clk);
    check("pre_reset_out_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    check("midreset_in_ready", 64'(bus.in_ready), 64'd1);
    check("midreset_out_illegal", 64'(bus.out_illegal), 64'd0);
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/immediate width (32 or 64).
REQ-002 SHALL have parameter ILEN, default 32, meaning instruction width (fixed 32).
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have flush  input  1  discard all held instructions.
REQ-006 SHALL have in_valid  input  1  upstream instruction present.
REQ-007 SHALL have in_ready  output  1  stage can accept; driven directly from a register.
REQ-008 SHALL have in_instr  input  ILEN  raw instruction bits.
REQ-009 SHALL have in_pc  input  XLEN  instruction address.
REQ-010 SHALL have out_valid  output  1  decoded instruction present.
REQ-011 SHALL have out_ready  input  1  downstream accepts.
REQ-012 SHALL have out_pc  output  XLEN  pc of presented instruction.
REQ-013 SHALL have out_opcode  output  4  0 UNKNOWN, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH, 6 LOAD, 7 STORE, 8 OP_IMM, 9 OP.
REQ-014 SHALL have out_rd, out_rs1, out_rs2  output  5 each  instr[11:7], [19:15], [24:20].
REQ-015 SHALL have out_funct3  output  3 and out_funct7  output  7  instr[14:12], [31:25].
REQ-016 SHALL have out_imm  output  XLEN  immediate selected by format (I/S/B/U/J; 0 for OP/UNKNOWN).
REQ-017 SHALL have out_illegal  output  1  instruction not decodable.

Function
REQ-018 SHALL map instr[6:2] to out_opcode per RV32I base opcodes; any other value or instr[1:0] != 2'b11 -> UNKNOWN with out_illegal=1.
REQ-019 SHALL sign-extend immediates from instr[31] to XLEN: I={[31:20]}, S={[31:25],[11:7]}, B={[31],[7],[30:25],[11:8],0}, J={[31],[19:12],[20],[30:21],0}; U={[31:12],12'b0} sign-extended above bit 31 when XLEN=64.
REQ-020 SHALL set out_illegal for OP when funct7 not in {0x00,0x20}, or funct7=0x20 with funct3 not in {0,5}; for JALR when funct3!=0.
REQ-021 SHALL be a registered stage: fields registered at acceptance; a transfer occurs when valid & ready high on the same edge.
REQ-022 SHALL hold a main register plus one skid register (capacity 2); in_ready = !skid_full.
REQ-023 SHALL, with both empty, present an accepted instruction on out_valid the next cycle (latency 1).
REQ-024 SHALL, when main is full, out_ready=0 and an input is accepted, place the input into skid.
REQ-025 SHALL, when main drains (out_ready=1) and skid full, move skid to main on that edge and clear skid.
REQ-026 SHALL preserve order; simultaneous accept and drain with skid empty loads the new instruction into main.
REQ-027 SHALL hold all out_* stable while out_valid=1 and out_ready=0.
REQ-028 SHALL, on flush, clear both valid bits on that edge, drop any same-cycle input, and keep in_ready=1 next cycle; flush overrides accept and drain.
REQ-029 SHALL hold out_* data fields at last value when out_valid=0 (don't-care to consumers).

Reset
REQ-030 SHALL, on reset, clear main and skid valid: out_valid=0, in_ready=1 next cycle, out_illegal=0; data registers cleared to 0.
REQ-031 SHALL, on reset mid-operation, discard held instructions; reset has priority over flush and handshakes.

Verification
REQ-032 SHALL verify: in 0xFFF00093 pc 0x100, out_ready=1 -> next cycle out_valid=1, OP_IMM, rd=1, rs1=0, imm=0xFFFFFFFF, illegal=0.
REQ-033 SHALL verify: in 0x00112623 -> STORE, rs1=2, rs2=1, funct3=2, imm=0x0000000C.
REQ-034 SHALL verify: in 0xFFDFF06F -> JAL, rd=0, imm=0xFFFFFFFC; in 0x0000007F -> UNKNOWN, illegal=1.
REQ-035 SHALL verify: out_ready=0, three back-to-back valids A,B,C -> A,B accepted, in_ready=0 at C; release out_ready -> A,B,C out in order, none lost.
REQ-036 SHALL verify: main+skid full, flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never emitted.
REQ-037 SHALL verify: reset asserted while out_valid=1 -> next cycle out_valid=0, in_ready=1; XLEN=64 build sign-extends U of 0x800000B7 to 0xFFFFFFFF80000000.
